vga_timing_gen: RTL and testbench

- Upstream stage of the VGA text/animation top level.
- Generates the 640x480@60 Hz raster timing at one pixel per clock: hsync, vsync, display_on, hpos, vpos, plus line/frame strobes and a speed-scaled animation frame counter.
- Replaces the ad-hoc frame counter in the consumer, which takes `hpos`, `vpos`, `display_on`, the syncs and `frame` directly from this block.
- All outputs are registered and mutually aligned.

---
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between vga_timing_gen and its consumer.
// The master drives the sync/position outputs; the slave drives en and speed.
interface vga_timing_if #(
  parameter int FRAME_W = 10
);
  logic               en;
  logic [1:0]         speed;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame;

  modport master (
    input  en, speed,
    output hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame
  );

  modport slave (
    output en, speed,
    input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator, one pixel per clock, with a speed-scaled
// animation frame counter. Every output is registered from the next-state counters.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FRAME_W   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_timing_if.master  bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0]         r_hpos;
  logic [9:0]         r_vpos;
  logic [2:0]         r_div;
  logic [FRAME_W-1:0] r_frame;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_display_on;
  logic               r_line_start;
  logic               r_frame_start;

  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_frame_wrap;
  logic [9:0]         w_hpos_nxt;
  logic [9:0]         w_vpos_nxt;
  logic [2:0]         w_mask;
  logic               w_frame_step;
  logic               w_display_nxt;
  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_line_nxt;
  logic               w_frame_nxt;

  always_comb begin
    w_h_wrap     = (r_hpos == H_LAST);
    w_v_wrap     = (r_vpos == V_LAST);
    w_frame_wrap = w_h_wrap && w_v_wrap;
    w_hpos_nxt   = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
    if (!w_h_wrap) begin
      w_vpos_nxt = r_vpos;
    end else if (w_v_wrap) begin
      w_vpos_nxt = 10'd0;
    end else begin
      w_vpos_nxt = r_vpos + 10'd1;
    end

    // mask = 2^speed - 1; div is compared before its own increment
    case (bus.speed)
      2'd0:    w_mask = 3'b000;
      2'd1:    w_mask = 3'b001;
      2'd2:    w_mask = 3'b011;
      default: w_mask = 3'b111;
    endcase
    w_frame_step = w_frame_wrap && ((r_div & w_mask) == w_mask);

    w_display_nxt = ({1'b0, w_hpos_nxt} < H_VIS) && ({1'b0, w_vpos_nxt} < V_VIS);
    w_hs_act      = ({1'b0, w_hpos_nxt} >= HS_START) && ({1'b0, w_hpos_nxt} < HS_END);
    w_vs_act      = ({1'b0, w_vpos_nxt} >= VS_START) && ({1'b0, w_vpos_nxt} < VS_END);
    w_line_nxt    = (w_hpos_nxt == 10'd0);
    w_frame_nxt   = w_line_nxt && (w_vpos_nxt == 10'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_div         <= '0;
      r_frame       <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_display_on  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (bus.en) begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      r_display_on  <= w_display_nxt;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_frame_nxt;
      if (w_frame_wrap) begin
        r_div <= r_div + 3'd1;
      end
      if (w_frame_step) begin
        r_frame <= r_frame + FRAME_W'(1);
      end
    end else begin
      // frozen: position and decodes hold, strobes must not repeat
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.hpos        = r_hpos;
  assign bus.vpos        = r_vpos;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.display_on  = r_display_on;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.frame       = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 15x10 raster so multi-frame behaviour
// (prescaler, frame wrap, enable gaps, reset) fits in a short run.
module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if #(.FRAME_W(FW)) vif ();

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_W(FW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(vif)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: linear pixel index within the frame plus frame-wrap count
  int m_p, m_wraps, m_frame;
  bit m_first, m_en_last;

  logic [28:0] obs;
  assign obs = {vif.hsync, vif.vsync, vif.display_on, vif.line_start, vif.frame_start,
                vif.hpos, vif.vpos, vif.frame};

  function automatic logic [28:0] exp_vec();
    int h, v;
    logic hs, vs, de, ls, fs;
    h = m_p % HT;
    v = m_p / HT;
    if (m_first) begin
      hs = 1'b1; vs = 1'b1; de = 1'b0;
    end else begin
      hs = !(h >= HD + HF && h < HD + HF + HS);
      vs = !(v >= VD + VF && v < VD + VF + VS);
      de = (h < HD) && (v < VD);
    end
    ls = m_en_last && !m_first && (h == 0);
    fs = ls && (v == 0);
    return {hs, vs, de, ls, fs, 10'(h), 10'(v), 4'(m_frame)};
  endfunction

  task automatic model_reset();
    m_p = 0; m_wraps = 0; m_frame = 0; m_first = 1'b1; m_en_last = 1'b0;
  endtask

  task automatic clk_step(input bit e);
    int mk;
    vif.en = e;
    @(posedge clk);
    #1;
    if (e) begin
      m_p     = (m_p + 1) % FT;
      m_first = 1'b0;
      if (m_p == 0) begin
        mk = (1 << int'(vif.speed)) - 1;
        if (((m_wraps % 8) & mk) == mk) m_frame = (m_frame + 1) % (1 << FW);
        m_wraps++;
      end
    end
    m_en_last = e;
    cyc++;
  endtask

  task automatic test_reset();
    vif.en = 1'b0;
    vif.speed = 2'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs, exp_vec());
    end
    checks++;
    if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin
      errors++; $display("FAIL reset_syncs got=%b%b exp=11", vif.hsync, vif.vsync);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_raster();
    int de_cnt = 0, last_ls = -1, last_fs = -1;
    vif.speed = 2'd0;
    for (int i = 0; i < 2 * FT + 5; i++) begin
      clk_step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL raster t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (vif.display_on) de_cnt++;
      if (vif.line_start) begin
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != HT) begin
            errors++; $display("FAIL line_period got=%0d exp=%0d", cyc - last_ls, HT);
          end
        end
        last_ls = cyc;
      end
      if (vif.frame_start) begin
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != FT) begin
            errors++; $display("FAIL frame_period got=%0d exp=%0d", cyc - last_fs, FT);
          end
        end
        last_fs = cyc;
      end
    end
    checks++;
    if (vif.frame !== 4'd2) begin
      errors++; $display("FAIL speed0_frame got=%0d exp=2", vif.frame);
    end
    // two full visible areas, minus the blanked first pixel, plus pixels 1..5 of line 0
    checks++;
    if (de_cnt != 2 * HD * VD + 5) begin
      errors++; $display("FAIL display_count got=%0d exp=%0d", de_cnt, 2 * HD * VD + 5);
    end
  endtask

  task automatic test_speed();
    int steps = 0, len;
    logic [FW-1:0] prev;
    vif.speed = 2'd2;
    prev = vif.frame;
    for (int i = 0; i < 8 * FT; i++) begin
      clk_step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL speed2 t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (vif.frame !== prev) steps++;
      prev = vif.frame;
    end
    checks++;
    if (steps != 2) begin
      errors++; $display("FAIL speed2_steps got=%0d exp=2", steps);
    end
    vif.speed = 2'd0;
    for (int i = 0; i <= FT && (m_p / HT) != 5; i++) clk_step(1'b1);
    vif.speed = 2'd1;
    for (int i = 0; i < 3 * FT; i++) begin
      clk_step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL speed_switch t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
    end
    for (int s = 0; s < 10; s++) begin
      vif.speed = 2'($urandom_range(0, 3));
      len = $urandom_range(20, 400);
      for (int i = 0; i < len; i++) begin
        clk_step(1'b1);
        checks++;
        if (obs !== exp_vec()) begin
          errors++; $display("FAIL speed_rand t=%0t got=%h exp=%h", $time, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_enable();
    int cnt = 0;
    bit found = 1'b0;
    logic [28:0] held;
    vif.speed = 2'd0;
    for (int i = 0; i <= FT && !found; i++) begin
      clk_step(1'b1);
      found = vif.frame_start;
    end
    for (int i = 0; i <= FT && m_p != 4 * HT + 3; i++) begin
      clk_step(1'b1); cnt++;
    end
    checks++;
    if (vif.hpos !== 10'd3 || vif.vpos !== 10'd4) begin
      errors++; $display("FAIL en_target got=%0d,%0d exp=3,4", vif.hpos, vif.vpos);
    end
    held = obs;
    for (int i = 0; i < 37; i++) begin
      clk_step(1'b0); cnt++;
      checks++;
      if (obs !== {held[28:26], 2'b00, held[23:0]}) begin
        errors++; $display("FAIL en_hold t=%0t got=%h exp=%h", $time, obs, {held[28:26], 2'b00, held[23:0]});
      end
    end
    clk_step(1'b1); cnt++;
    checks++;
    if (vif.hpos !== 10'd4) begin
      errors++; $display("FAIL en_resume got=%0d exp=4", vif.hpos);
    end
    found = 1'b0;
    for (int i = 0; i <= FT && !found; i++) begin
      clk_step(1'b1); cnt++;
      found = vif.frame_start;
    end
    checks++;
    if (cnt != FT + 37) begin
      errors++; $display("FAIL en_frame_period got=%0d exp=%0d", cnt, FT + 37);
    end
    for (int i = 0; i < 400; i++) begin
      clk_step($urandom_range(0, 3) != 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL en_rand t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
    end
  endtask

  task automatic test_frame_wrap();
    bit saw_wrap = 1'b0;
    logic [FW-1:0] prev;
    vif.speed = 2'd3;
    prev = vif.frame;
    for (int i = 0; i < ((1 << FW) * 8 + 1) * FT; i++) begin
      clk_step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL speed3 t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (prev == 4'd15 && vif.frame == 4'd0) saw_wrap = 1'b1;
      prev = vif.frame;
    end
    checks++;
    if (!saw_wrap) begin
      errors++; $display("FAIL frame_wrap got=no_wrap exp=15_to_0");
    end
  endtask

  task automatic test_reset_mid();
    int k = -1;
    vif.speed = 2'd0;
    for (int i = 0; i <= FT && m_p != 8 * HT + 13; i++) clk_step(1'b1);
    checks++;
    if (obs !== exp_vec() || vif.vsync !== 1'b0) begin
      errors++; $display("FAIL pre_reset got=%h exp=%h", obs, exp_vec());
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== {3'b110, 2'b00, 10'd0, 10'd0, 4'd0}) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs, {3'b110, 2'b00, 10'd0, 10'd0, 4'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= FT + 5; i++) begin
      clk_step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL post_reset t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (vif.frame_start && k < 0) k = i;
    end
    checks++;
    if (k != FT) begin
      errors++; $display("FAIL first_frame_start got=%0d exp=%0d", k, FT);
    end
  endtask

  initial begin
    vif.en = 1'b0;
    vif.speed = 2'd0;
    test_reset();
    test_raster();
    test_speed();
    test_enable();
    test_frame_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
